// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared types and helpers for the PDM CIC decimator
package pdm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    // Accumulator width that holds DECIMATION^ORDER plus sign and headroom
    function automatic int acc_width(input int order, input int dec);
        return order * $clog2(dec) + 2;
    endfunction

    // Channel 0 samples just before the rising edge of pdm_clk
    function automatic int ch0_phase(input int div);
        return div - 1;
    endfunction

    // Channel 1 samples just before the falling edge of pdm_clk
    function automatic int ch1_phase(input int div);
        return div / 2 - 1;
    endfunction

    // Number of phases per bit period during which pdm_clk is high
    function automatic int high_phases(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/pdm_cic_channel.sv
// rtl/pdm_cic_channel.sv - one channel of integrators and pipelined combs
module cic_channel #(
    parameter int ORDER      = 4,
    parameter int ACC_W      = 26,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  bit_en,
    input  logic                  data_bit,
    input  logic                  strobe,
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  sample_valid
);

    logic signed [ACC_W-1:0] integ    [ORDER];
    logic signed [ACC_W-1:0] comb_dly [ORDER];
    logic signed [ACC_W-1:0] comb_out [ORDER];
    logic [ORDER-1:0]        stage_valid;
    logic signed [ACC_W-1:0] step;

    // Bit 1 contributes +1, bit 0 contributes -1
    assign step = data_bit ? ACC_W'(1) : '1;

    // Integrator chain, one update per PDM bit; wrap-around is cancelled by the combs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ORDER; i++) integ[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < ORDER; i++) integ[i] <= '0;
        end else if (bit_en) begin
            integ[0] <= integ[0] + step;
            for (int i = 1; i < ORDER; i++) integ[i] <= integ[i] + integ[i-1];
        end
    end

    // Comb chain, one stage per clk after the decimation strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            for (int i = 0; i < ORDER; i++) begin
                comb_dly[i] <= '0;
                comb_out[i] <= '0;
            end
        end else if (clear) begin
            stage_valid <= '0;
            for (int i = 0; i < ORDER; i++) begin
                comb_dly[i] <= '0;
                comb_out[i] <= '0;
            end
        end else begin
            stage_valid[0] <= strobe;
            for (int i = 1; i < ORDER; i++) stage_valid[i] <= stage_valid[i-1];
            if (strobe) begin
                comb_out[0] <= integ[ORDER-1] - comb_dly[0];
                comb_dly[0] <= integ[ORDER-1];
            end
            for (int i = 1; i < ORDER; i++) begin
                if (stage_valid[i-1]) begin
                    comb_out[i] <= comb_out[i-1] - comb_dly[i];
                    comb_dly[i] <= comb_out[i-1];
                end
            end
        end
    end

    assign sample       = comb_out[ORDER-1][ACC_W-1 -: DATA_WIDTH];
    assign sample_valid = stage_valid[ORDER-1];

endmodule

// File: rtl/pdm_cic_decimator.sv
// rtl/pdm_cic_decimator.sv - PDM microphone front end with CIC decimation to PCM
module pdm_cic_decimator
    import pdm_pkg::*;
#(
    parameter int PDM_CLK_DIV = 32,
    parameter int CHANNELS    = 1,
    parameter int CIC_ORDER   = 4,
    parameter int DECIMATION  = 64,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    output logic                           pdm_clk,
    input  logic                           pdm_data,
    output logic [CHANNELS*DATA_WIDTH-1:0] pcm_data,
    output logic                           pcm_valid,
    input  logic                           pcm_ready,
    output logic                           overrun,
    input  logic                           overrun_clr
);

    localparam int ACC_W = acc_width(CIC_ORDER, DECIMATION);
    localparam int CNT_W = $clog2(PDM_CLK_DIV);
    localparam int BIT_W = $clog2(DECIMATION);
    localparam int SET_W = $clog2(CIC_ORDER + 1);

    localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PDM_CLK_DIV - 1);
    localparam logic [CNT_W-1:0] PH_HIGH  = CNT_W'(high_phases(PDM_CLK_DIV));
    localparam logic [CNT_W-1:0] PH_CH0   = CNT_W'(ch0_phase(PDM_CLK_DIV));
    localparam logic [CNT_W-1:0] PH_CH1   = CNT_W'(ch1_phase(PDM_CLK_DIV));
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DECIMATION - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(CIC_ORDER - 1);

    state_t                         state;
    logic [SET_W-1:0]               settle_cnt;
    logic [CNT_W-1:0]               phase_cnt;
    logic [CNT_W-1:0]               phase_next;
    logic [BIT_W-1:0]               bit_cnt;
    logic [1:0]                     sync_q;
    logic                           running;
    logic                           clear;
    logic                           strobe;
    logic                           strobe_pend;
    logic                           frame_valid;
    logic                           deliver;
    logic [CHANNELS-1:0]            ch_bit_en;
    logic [CHANNELS-1:0]            ch_valid;
    logic [DATA_WIDTH-1:0]          ch_sample [CHANNELS];
    logic [CHANNELS*DATA_WIDTH-1:0] frame;

    assign running     = enable && (state != IDLE);
    assign clear       = !running;
    assign frame_valid = &ch_valid;
    assign deliver     = frame_valid && running && (state == RUN);

    // Phase counter only advances while capturing; otherwise it sits at zero
    assign phase_next = !running ? '0 :
                        (phase_cnt == PH_LAST) ? '0 : phase_cnt + 1'b1;

    // Per-channel sample enables at the two edge-adjacent phases
    always_comb begin
        ch_bit_en    = '0;
        ch_bit_en[0] = running && (phase_cnt == PH_CH0);
        if (CHANNELS > 1) ch_bit_en[CHANNELS-1] = running && (phase_cnt == PH_CH1);
    end

    // Pack channel samples, channel 0 in the least significant slice
    always_comb begin
        frame = '0;
        for (int c = 0; c < CHANNELS; c++) frame[c*DATA_WIDTH +: DATA_WIDTH] = ch_sample[c];
    end

    // Bit clock generation, registered from the next phase so it lines up with the counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
            pdm_clk   <= 1'b0;
        end else begin
            phase_cnt <= phase_next;
            pdm_clk   <= enable && (phase_next < PH_HIGH);
        end
    end

    // Two-flop synchroniser for the asynchronous data line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], pdm_data};
    end

    // Bit counter and decimation strobe; stereo waits for channel 1 to finish the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            strobe      <= 1'b0;
            strobe_pend <= 1'b0;
        end else if (!running) begin
            bit_cnt     <= '0;
            strobe      <= 1'b0;
            strobe_pend <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (ch_bit_en[0]) bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            if (CHANNELS == 1) begin
                strobe <= ch_bit_en[0] && (bit_cnt == BIT_LAST);
            end else if (ch_bit_en[0] && (bit_cnt == BIT_LAST)) begin
                strobe_pend <= 1'b1;
            end else if (ch_bit_en[CHANNELS-1] && strobe_pend) begin
                strobe      <= 1'b1;
                strobe_pend <= 1'b0;
            end
        end
    end

    // Capture state machine; the first CIC_ORDER frames only fill the comb history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else if (!enable) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= SETTLE;
                    settle_cnt <= '0;
                end
                SETTLE: begin
                    if (frame_valid) begin
                        settle_cnt <= settle_cnt + 1'b1;
                        if (settle_cnt == SET_LAST) state <= RUN;
                    end
                end
                RUN:     state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        cic_channel #(
            .ORDER      (CIC_ORDER),
            .ACC_W      (ACC_W),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_cic (
            .clk          (clk),
            .rst_n        (rst_n),
            .clear        (clear),
            .bit_en       (ch_bit_en[c]),
            .data_bit     (sync_q[1]),
            .strobe       (strobe),
            .sample       (ch_sample[c]),
            .sample_valid (ch_valid[c])
        );
    end

    // Output register with valid/ready handshake; a newer frame overwrites and flags overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (deliver) begin
                pcm_data  <= frame;
                pcm_valid <= 1'b1;
            end else if (pcm_valid && pcm_ready) begin
                pcm_valid <= 1'b0;
            end
            if (deliver && pcm_valid && !pcm_ready) overrun <= 1'b1;
            else if (overrun_clr)                   overrun <= 1'b0;
        end
    end

endmodule

// File: doc/pdm_cic_decimator.md
Name: pdm_cic_decimator

Overview:
- Parametrised PDM-to-PCM front end: generates the microphone bit clock and samples 1 or 2 PDM channels on opposite clock edges.
- Each channel runs through an N-order CIC decimator (integrators at PDM rate, pipelined combs at the decimated rate).
- Delivers one PCM frame, all channels, through a valid/ready handshake with overrun detection.
- Sits between the PDM microphone pins and the audio FIFO/DMA logic, all in the system clock domain.

Parameters:
- PDM_CLK_DIV, 32: system clocks per PDM bit; even, >=8.
- CHANNELS, 1: 1 (mono) or 2 (stereo on shared data line).
- CIC_ORDER, 4: integrator/comb stages, 1..5.
- DECIMATION, 64: PDM bits per output sample; power of two, 8..256.
- DATA_WIDTH, 16: PCM sample width; must be <= ACC_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  capture enable.
- pdm_clk  out  1  microphone bit clock, registered.
- pdm_data  in  1  PDM data line, asynchronous.
- pcm_data  out  CHANNELS*DATA_WIDTH  frame; channel 0 in the LSB slice.
- pcm_valid  out  1  frame available.
- pcm_ready  in  1  consumer accepts frame.
- overrun  out  1  sticky: a frame was lost.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset is asynchronous, active-low, on clk only. Reset values:
  - pdm_clk=0, pcm_data=0, pcm_valid=0, overrun=0.
  - All integrators, combs and counters = 0; FSM = IDLE.
- Width: ACC_W = CIC_ORDER*log2(DECIMATION)+2, signed two's complement.
  - Input bit 1 maps to +1, bit 0 maps to -1.
  - Integrators wrap modulo 2^ACC_W; wrap is intentional and cancelled by the combs.
- Clock generation: phase counter 0..PDM_CLK_DIV-1.
  - pdm_clk = 1 while the counter < PDM_CLK_DIV/2, else 0. Duty cycle is exactly 50%.
- Input: pdm_data passes through a 2-FF synchroniser.
  - Channel 0 samples the synchronised bit at counter == PDM_CLK_DIV-1 (just before the rising edge).
  - Channel 1, if present, samples at counter == PDM_CLK_DIV/2-1 (just before the falling edge).
- Integrators: each channel's integrator chain updates once per PDM bit, in the cycle its sample is taken.
- Decimation strobe: a bit counter 0..DECIMATION-1 advances on each channel-0 sample. The strobe fires after exactly DECIMATION bits.
  - Stereo: the strobe is issued after the channel-1 sample that completes the same frame.
- Combs: pipelined, one stage per clk cycle. Each stage keeps a delay register of its input from the previous strobe.
  - Output = top DATA_WIDTH bits of the last comb stage (truncation, no rounding).
  - +full-scale (+DECIMATION^CIC_ORDER) maps to 2^(DATA_WIDTH-2) and cannot overflow.
  - Latency: pcm_valid rises CIC_ORDER+1 clk after the strobe.
- FSM (shared package enum):
  - IDLE: pdm_clk held 0, datapath cleared, counters held at 0. Go to SETTLE when enable=1.
  - SETTLE: filter runs, but the first CIC_ORDER frames are discarded (no pcm_valid). Go to RUN after CIC_ORDER strobes.
  - RUN: frames delivered.
  - enable=0 in any state: go to IDLE on the next cycle; pdm_clk is forced 0 and the datapath is cleared. A pending pcm_valid is kept until it is accepted.
- Handshake:
  - pcm_data is stable while pcm_valid=1 and pcm_ready=0.
  - Transfer happens on pcm_valid&pcm_ready; pcm_valid drops the next cycle unless a new frame lands in the same cycle.
  - New frame while pcm_valid=1 and no transfer: overwrite pcm_data, keep pcm_valid=1, set overrun.
  - New frame in the same cycle as a transfer: no overrun; pcm_valid stays 1 with the new data.
  - overrun_clr clears the flag; if a set event coincides with overrun_clr, set wins.
- Reset asserted mid-frame: immediate return to reset values. No partial frame is ever presented.

Decomposition:
- Package pdm_pkg:
  - state enum (IDLE, SETTLE, RUN).
  - acc_width(order, dec) function.
  - sample-phase constants derived from PDM_CLK_DIV.
- Sub-module cic_channel (one instance per channel):
  - Inputs: clk, rst_n, clear, bit_en, bit, strobe.
  - Outputs: sample, sample_valid.
  - Contains the integrator chain and the pipelined comb chain.
- Top level contains clock generation, synchroniser, counters, FSM and output register/handshake.

Test Plan:
- Defaults, pdm_data constant 1, pcm_ready=1:
  - First pcm_valid after (CIC_ORDER+1)*64 PDM bits plus pipeline latency.
  - Steady-state pcm_data = 0x4000.
  - Frame spacing = 64*32 = 2048 clk.
- Constant 0 -> steady-state 0xC000. Alternating 1/0 per bit -> steady-state 0x0000.
- CHANNELS=2, drive 1 in the rising-edge window and 0 in the falling-edge window -> channel 0 = 0x4000, channel 1 = 0xC000.
  - Check pdm_clk period = 32 clk, high for 16.
- Hold pcm_ready=0 across two frames -> pcm_data = second frame, overrun=1.
  - Pulse overrun_clr -> overrun=0.
  - Assert overrun_clr in the same cycle as the next loss -> overrun stays 1.
- Toggle enable=0 mid-frame -> pdm_clk=0 within 1 clk, no partial frame, unconsumed frame stays valid.
  - Re-enable -> CIC_ORDER frames discarded, then correct values.
- Assert rst_n=0 asynchronously mid-comb-pipeline -> all outputs at reset values before the next clk edge.
